// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser, per-bit stability counter,
// and single-cycle rise/fall event pulses aligned with the debounced word.
module sw_debounce #(
  parameter int unsigned NUM_SW          = 17,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_SW-1:0] sw_i,
  output logic [31:0]       sw_o,
  output logic [NUM_SW-1:0] sw_rise_o,
  output logic [NUM_SW-1:0] sw_fall_o,
  output logic              sw_event_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;
  logic [NUM_SW-1:0] stable_q;
  logic [NUM_SW-1:0] stable_d_q;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];

  // Metastability guard: plain two-flop chain, nothing between the stages
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit stability counter; any return to the stable value forfeits progress
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= '0;
      for (int i = 0; i < int'(NUM_SW); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SW); i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_d_q <= '0;
    end else begin
      stable_d_q <= stable_q;
    end
  end

  assign sw_o       = 32'(stable_q);
  assign sw_rise_o  = stable_q & ~stable_d_q;
  assign sw_fall_o  = ~stable_q & stable_d_q;
  assign sw_event_o = |{sw_rise_o, sw_fall_o};

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: main instance (17 bits, 4-cycle debounce)
// plus a corner instance (32 bits, 1-cycle debounce).
module tb_sw_debounce;

  logic        clk;
  logic        rst_n;
  logic [16:0] sw;
  logic [31:0] sw_out;
  logic [16:0] rise;
  logic [16:0] fall;
  logic        ev;

  logic        rst2_n;
  logic [31:0] sw2;
  logic [31:0] sw2_out;
  logic [31:0] rise2;
  logic [31:0] fall2;
  logic        ev2;

  int n_tests = 0;
  int n_fail  = 0;
  logic        seen_rise0;
  logic [31:0] exp_word;

  sw_debounce #(.NUM_SW(17), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_i(sw),
    .sw_o(sw_out), .sw_rise_o(rise), .sw_fall_o(fall), .sw_event_o(ev)
  );

  sw_debounce #(.NUM_SW(32), .DEBOUNCE_CYCLES(1)) u_dut_corner (
    .clk_i(clk), .rst_ni(rst2_n), .sw_i(sw2),
    .sw_o(sw2_out), .sw_rise_o(rise2), .sw_fall_o(fall2), .sw_event_o(ev2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    sw     = 17'h1FFFF;
    sw2    = 32'h0;
    repeat (3) step();

    // Reset state
    check("rst_sw_o",  sw_out, 32'h0);
    check("rst_rise",  32'(rise), 32'h0);
    check("rst_fall",  32'(fall), 32'h0);
    check("rst_event", 32'(ev), 32'h0);

    // Release with all switches high: accepted on 6th edge after release
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("rel_e5_sw_o", sw_out, 32'h0);
    step();
    check("rel_e6_sw_o",  sw_out, 32'h0001FFFF);
    check("rel_e6_rise",  32'(rise), 32'h1FFFF);
    check("rel_e6_event", 32'(ev), 32'h1);
    step();
    check("rel_e7_rise",  32'(rise), 32'h0);
    check("rel_e7_event", 32'(ev), 32'h0);
    check("rel_e7_sw_o",  sw_out, 32'h0001FFFF);

    // Drop everything, then a clean single-bit rise on bit 3
    @(negedge clk);
    sw = 17'h0;
    repeat (10) step();
    check("clr_sw_o", sw_out, 32'h0);
    @(negedge clk);
    sw[3] = 1'b1;
    repeat (5) step();
    check("clean_e5_sw_o", sw_out, 32'h0);
    step();
    check("clean_e6_sw_o", sw_out, 32'h8);
    check("clean_e6_rise", 32'(rise), 32'h8);
    check("clean_e6_fall", 32'(fall), 32'h0);
    step();
    check("clean_e7_rise", 32'(rise), 32'h0);

    // Bounce on bit 0: 3-cycle highs never reach acceptance
    seen_rise0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      sw[0] = 1'b1;
      repeat (3) begin step(); seen_rise0 |= rise[0] | sw_out[0]; end
      @(negedge clk);
      sw[0] = 1'b0;
      repeat (3) begin step(); seen_rise0 |= rise[0] | sw_out[0]; end
    end
    repeat (4) begin step(); seen_rise0 |= rise[0] | sw_out[0]; end
    check("bounce_no_accept", 32'(seen_rise0), 32'h0);
    check("bounce_sw_o", sw_out, 32'h8);
    @(negedge clk);
    sw[0] = 1'b1;
    repeat (5) step();
    check("hold_e5_sw_o", sw_out, 32'h8);
    step();
    check("hold_e6_sw_o", sw_out, 32'h9);
    check("hold_e6_rise", 32'(rise), 32'h1);
    repeat (4) step();
    check("hold_e10_sw_o", sw_out, 32'h9);

    // Simultaneous fall on bit 5 and rise on bit 9
    @(negedge clk);
    sw[5] = 1'b1;
    repeat (10) step();
    check("pre_sim_sw_o", sw_out, 32'h29);
    @(negedge clk);
    sw[5] = 1'b0;
    sw[9] = 1'b1;
    repeat (5) step();
    check("sim_e5_event", 32'(ev), 32'h0);
    step();
    check("sim_e6_fall",  32'(fall), 32'h20);
    check("sim_e6_rise",  32'(rise), 32'h200);
    check("sim_e6_event", 32'(ev), 32'h1);
    check("sim_e6_sw_o",  sw_out, 32'h209);
    step();
    check("sim_e7_event", 32'(ev), 32'h0);

    // Reset in the middle of a count on bit 2
    @(negedge clk);
    sw[2] = 1'b1;
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_async_sw_o", sw_out, 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    exp_word = 32'h20D;
    repeat (5) step();
    check("midrst_e5_sw_o", sw_out, 32'h0);
    step();
    check("midrst_e6_sw_o", sw_out, exp_word);
    check("midrst_e6_rise", 32'(rise), exp_word);

    // Corner instance: 32 bits, single-cycle debounce
    check("c_rst_sw_o", sw2_out, 32'h0);
    @(negedge clk);
    rst2_n = 1'b1;
    step();
    @(negedge clk);
    sw2 = 32'hA5A5_5A5A;
    repeat (2) step();
    check("c_e2_sw_o", sw2_out, 32'h0);
    step();
    check("c_e3_sw_o",  sw2_out, 32'hA5A5_5A5A);
    check("c_e3_rise",  rise2, 32'hA5A5_5A5A);
    check("c_e3_event", 32'(ev2), 32'h1);
    @(negedge clk);
    sw2 = 32'hFFFF_0000;
    repeat (3) step();
    check("c2_e3_sw_o", sw2_out, 32'hFFFF_0000);
    check("c2_e3_rise", rise2, 32'h5A5A_0000);
    check("c2_e3_fall", fall2, 32'h0000_5A5A);
    step();
    check("c2_e4_event", 32'(ev2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input conditioning stage directly upstream of the core's switch I/O port (io_sw_i).
- Synchronises the asynchronous board slide switches (SW[16:0]) into the CPU clock domain, then debounces each bit independently with a stability counter.
- Presents a clean 32-bit switch word (zero-extended) plus one-cycle rise/fall event pulses.
- The board top instantiates it between the SW pins and the core; SW[17] stays the reset source and is not routed through this block.

Parameters:
- NUM_SW, 17, number of switch bits conditioned (1..32).
- DEBOUNCE_CYCLES, 1000000, clock cycles a synchronised bit must hold a new value before it is accepted (20 ms at 50 MHz); must be >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-bit counter; derived, not overridden.

Ports:
- clk_i  input  1  system clock (CLOCK_50 at the board top).
- rst_ni  input  1  asynchronous active-low reset.
- sw_i  input  NUM_SW  raw asynchronous switch pins.
- sw_o  output  32  debounced switch word; bits [NUM_SW-1:0] are stable values, upper bits are 0; drives io_sw_i.
- sw_rise_o  output  NUM_SW  one-cycle pulse per bit when its debounced value goes 0->1.
- sw_fall_o  output  NUM_SW  one-cycle pulse per bit when its debounced value goes 1->0.
- sw_event_o  output  1  OR of all rise/fall bits in the same cycle.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni; every flop clears immediately on assertion, with no clock required.
- Reset values: sync stages = 0, stable = 0, counters = 0. Therefore sw_o = 0, and sw_rise_o, sw_fall_o and sw_event_o are all 0.
- Synchroniser: two-flop chain per bit (sync1 <= sw_i; sync2 <= sync1). No logic between the two flops. Only sync2 is used downstream.
- Per-bit debounce, evaluated every cycle:
  - If sync2 == stable: counter <= 0.
  - If sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0, and the matching rise or fall pulse fires on the next cycle, aligned with the new sw_o value.
- Glitch rejection: any return of sync2 to the stable value before acceptance clears the counter. A new attempt then restarts from 0; there is no partial credit.
- Latency: a clean change on sw_i that is held meets the following timing.
  - It reaches sync2 after 2 rising edges.
  - sw_o changes DEBOUNCE_CYCLES edges later, for 2+DEBOUNCE_CYCLES edges in total.
  - With DEBOUNCE_CYCLES=1, every synchronised change is accepted on the next edge, for a total of 3.
- Pulses:
  - sw_rise_o[i] = stable[i] & ~stable_q[i]; sw_fall_o[i] = ~stable[i] & stable_q[i], where stable_q is a one-cycle delayed copy of stable that resets to 0. A bit's rise and fall pulses are mutually exclusive.
  - Each pulse is high for exactly one cycle and coincides with the first cycle of the new sw_o value.
  - A change that is rejected produces no pulse.
- Independence: bits have separate counters. Simultaneous changes on several bits each produce their own pulses in the same cycle if their timing matches. sw_event_o is high in that cycle.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-operation: asserting rst_ni during a count discards all progress. After release, stable starts at 0, so any switch already high is accepted after 2+DEBOUNCE_CYCLES cycles and generates a rise pulse.
- Width rules: sw_o[31:NUM_SW] is tied to 0. With NUM_SW=32 there is no padding.
- Output timing: all outputs are registered, or driven by purely combinational logic from registered state. There is no combinational path from sw_i to any output.

Test Plan (DEBOUNCE_CYCLES=4, NUM_SW=17 in simulation):
- Reset check: hold rst_ni=0 with sw_i=17'h1FFFF -> sw_o=0 and all pulses 0. Release rst_ni at edge 0 -> sw_o=32'h0001FFFF at edge 6, sw_rise_o=17'h1FFFF for exactly one cycle, sw_event_o=1 for that cycle.
- Clean change: sw_i[3] goes 0->1 and is held -> sw_o[3]=1 after 6 edges, sw_rise_o[3] pulses once, all other bits are unchanged.
- Bounce rejection: toggle sw_i[0] high for 3 cycles then low, repeated 5 times -> sw_o[0] stays 0, no pulse. Then hold high for 10 cycles -> accepted 6 edges after the final rise.
- Simultaneous events: sw_i[5] 1->0 and sw_i[9] 0->1 on the same cycle -> sw_fall_o[5] and sw_rise_o[9] pulse in the same cycle, and sw_event_o=1 for one cycle only.
- Reset mid-count: start a change on sw_i[2], assert rst_ni after 3 cycles, release -> no early acceptance; sw_o[2] is set exactly 6 edges after release.
- Parameter corner: DEBOUNCE_CYCLES=1 -> every held change is accepted at edge 3 and the counter never leaves 0. NUM_SW=32 -> no zero padding and all 32 bits track.
